// File: rtl/sdram_pkg.sv
// Shared types for the SDRAM command issuer: FSM states, request record and
// the default address widths used by the issuer and its optional statistics.
package sdram_pkg;

    localparam int DEFAULT_ROW_WIDTH  = 14;
    localparam int DEFAULT_COL_WIDTH  = 10;
    localparam int DEFAULT_BANK_WIDTH = 2;
    localparam int STAT_WIDTH         = 16;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        SEND_PRE,
        WAIT_PRE,
        SEND_ACT,
        WAIT_ACT,
        ISSUE
    } issuer_state_t;

    typedef logic [DEFAULT_ROW_WIDTH-1:0] bank_row_t;

    typedef struct packed {
        logic                          write;
        logic [DEFAULT_BANK_WIDTH-1:0] bank;
        bank_row_t                     row;
        logic [DEFAULT_COL_WIDTH-1:0]  col;
    } mem_req_t;

    function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] value);
        return (value == {STAT_WIDTH{1'b1}}) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/sdram_issuer_stats.sv
// Saturating hit/miss/conflict counters for the command issuer.
// Only instantiated when SDRAM_ISSUER_STATS_EN is defined.
module sdram_issuer_stats
    import sdram_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hit,
    input  logic                  miss,
    input  logic                  conflict,
    output logic [STAT_WIDTH-1:0] stat_hits,
    output logic [STAT_WIDTH-1:0] stat_misses,
    output logic [STAT_WIDTH-1:0] stat_conflicts
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_hits      <= '0;
            stat_misses    <= '0;
            stat_conflicts <= '0;
        end else begin
            if (hit)      stat_hits      <= sat_inc(stat_hits);
            if (miss)     stat_misses    <= sat_inc(stat_misses);
            if (conflict) stat_conflicts <= sat_inc(stat_conflicts);
        end
    end

endmodule

// File: rtl/sdram_cmd_issuer.sv
// Single-request SDRAM command scheduler: opens the target row through the bank
// tracker, then presents RD/WR. Optional counters under SDRAM_ISSUER_STATS_EN.
module sdram_cmd_issuer
    import sdram_pkg::*;
#(
    parameter int ROW_WIDTH       = DEFAULT_ROW_WIDTH,
    parameter int COL_WIDTH       = DEFAULT_COL_WIDTH,
    parameter int NUM_GROUPS      = 2,
    parameter int BANKS_PER_GROUP = 2,
    parameter int BANKS           = NUM_GROUPS * BANKS_PER_GROUP,
    parameter int BANK_WIDTH      = $clog2(BANKS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_write,
    input  logic [BANK_WIDTH-1:0]      req_bank,
    input  logic [ROW_WIDTH-1:0]       req_row,
    input  logic [COL_WIDTH-1:0]       req_col,
    input  logic [BANKS-1:0]           bank_ready,
    input  logic [BANKS-1:0]           bank_active,
    input  logic [BANKS-1:0]           bank_blocked,
    input  logic [BANKS*ROW_WIDTH-1:0] bank_active_row,
    output logic [BANKS-1:0]           precharge,
    output logic [BANKS-1:0]           activate,
    output logic [ROW_WIDTH-1:0]       row_address,
    output logic                       cmd_valid,
    input  logic                       cmd_ready,
    output logic                       cmd_write,
    output logic [BANK_WIDTH-1:0]      cmd_bank,
    output logic [COL_WIDTH-1:0]       cmd_col
`ifdef SDRAM_ISSUER_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0]      stat_hits,
    output logic [STAT_WIDTH-1:0]      stat_misses,
    output logic [STAT_WIDTH-1:0]      stat_conflicts
`endif
);

    generate
        if ((BANKS & (BANKS - 1)) != 0) begin : g_banks_pow2
            $error("sdram_cmd_issuer: BANKS must be a power of two");
        end
    endgenerate

    issuer_state_t state, state_next;

    logic                  write_q;
    logic [BANK_WIDTH-1:0] bank_q;
    logic [ROW_WIDTH-1:0]  row_q;
    logic [COL_WIDTH-1:0]  col_q;

    logic                  cur_blocked;
    logic                  cur_active;
    logic                  cur_ready;
    logic [ROW_WIDTH-1:0]  cur_open_row;
    logic                  row_hit;
    logic [BANKS-1:0]      bank_onehot;

    always_comb begin
        cur_open_row = '0;
        for (int i = 0; i < BANKS; i++) begin
            if (bank_q == BANK_WIDTH'(i))
                cur_open_row = bank_active_row[i*ROW_WIDTH +: ROW_WIDTH];
        end
    end

    assign cur_blocked = bank_blocked[bank_q];
    assign cur_active  = bank_active[bank_q];
    assign cur_ready   = bank_ready[bank_q];
    assign row_hit     = (cur_open_row == row_q);
    assign bank_onehot = BANKS'(1) << bank_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Request fields are captured only on the handshake and held until the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_q <= 1'b0;
            bank_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
        end else if (state == IDLE && req_valid) begin
            write_q <= req_write;
            bank_q  <= req_bank;
            row_q   <= req_row;
            col_q   <= req_col;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (req_valid) state_next = CHECK;
            CHECK: begin
                if (cur_blocked)                state_next = CHECK;
                else if (cur_active && row_hit) state_next = ISSUE;
                else if (cur_active)            state_next = SEND_PRE;
                else                            state_next = SEND_ACT;
            end
            SEND_PRE: state_next = WAIT_PRE;
            // The tracker registers the pulse, so blocked is already high on
            // the first WAIT cycle and cannot be missed here.
            WAIT_PRE: if (!cur_blocked) state_next = CHECK;
            SEND_ACT: state_next = WAIT_ACT;
            WAIT_ACT: if (!cur_blocked && cur_ready) state_next = ISSUE;
            ISSUE:    if (cmd_ready) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready   = (state == IDLE);
        precharge   = (state == SEND_PRE) ? bank_onehot : '0;
        activate    = (state == SEND_ACT) ? bank_onehot : '0;
        cmd_valid   = (state == ISSUE);
        row_address = row_q;
        cmd_write   = write_q;
        cmd_bank    = bank_q;
        cmd_col     = col_q;
    end

`ifdef SDRAM_ISSUER_STATS_EN
    // Only the first unblocked CHECK of a request is classified; the CHECK
    // revisited after a precharge is not counted again.
    logic first_check_q;
    logic classify;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                 first_check_q <= 1'b0;
        else if (state == IDLE && req_valid)     first_check_q <= 1'b1;
        else if (state == CHECK && !cur_blocked) first_check_q <= 1'b0;
    end

    assign classify = (state == CHECK) && first_check_q && !cur_blocked;

    sdram_issuer_stats u_stats (
        .clk            (clk),
        .rst            (rst),
        .hit            (classify && cur_active && row_hit),
        .miss           (classify && !cur_active),
        .conflict       (classify && cur_active && !row_hit),
        .stat_hits      (stat_hits),
        .stat_misses    (stat_misses),
        .stat_conflicts (stat_conflicts)
    );
`endif

endmodule

// File: doc/sdram_cmd_issuer.md
Name: sdram_cmd_issuer

Overview:
- Per-request command scheduler that sits directly upstream of the SDRAM bank-state tracker.
- Accepts one memory request at a time and inspects the tracker's per-bank state (active, ready, blocked, open row).
- Drives one-cycle precharge/activate pulses into the tracker until the target row is open, then presents a column command (RD/WR) to the downstream data path.
- One request in flight at a time; no reordering.

Parameters:
- ROW_WIDTH, 14, row address bits
- COL_WIDTH, 10, column address bits
- NUM_GROUPS, 2, bank groups
- BANKS_PER_GROUP, 2, banks per group
- BANKS, NUM_GROUPS*BANKS_PER_GROUP, total banks; must be a power of two (elaboration-time check)
- BANK_WIDTH, $clog2(BANKS), bank index bits

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request offered
- req_ready  out  1  request accepted when req_valid & req_ready
- req_write  in  1  1=write, 0=read
- req_bank  in  BANK_WIDTH  target bank
- req_row  in  ROW_WIDTH  target row
- req_col  in  COL_WIDTH  target column
- bank_ready  in  BANKS  tracker ready_to_access
- bank_active  in  BANKS  tracker active_bank
- bank_blocked  in  BANKS  tracker blocked
- bank_active_row  in  BANKS*ROW_WIDTH  tracker open row per bank, bank i at [i*ROW_WIDTH +: ROW_WIDTH]
- precharge  out  BANKS  one-hot precharge pulse to tracker
- activate  out  BANKS  one-hot activate pulse to tracker
- row_address  out  ROW_WIDTH  row for activate; equals latched row whenever activate is nonzero
- cmd_valid  out  1  column command valid
- cmd_ready  in  1  downstream accepts command
- cmd_write  out  1  latched req_write
- cmd_bank  out  BANK_WIDTH  latched bank
- cmd_col  out  COL_WIDTH  latched column

Behaviour:
- Reset (async, immediate): state=IDLE; req_ready=1 once out of reset; precharge=0, activate=0, cmd_valid=0; row_address, cmd_write, cmd_bank and cmd_col are 0.
- Outputs are Moore-decoded from state plus registered latches; there are no combinational paths from the bank_* inputs to any output.
- States: IDLE, CHECK, SEND_PRE, WAIT_PRE, SEND_ACT, WAIT_ACT, ISSUE.
- IDLE: req_ready=1. On a handshake, latch write/bank/row/col and go to CHECK. req_ready is 0 in every other state.
- CHECK: b = latched bank.
  - bank_blocked[b] -> stay in CHECK.
  - bank_active[b] and open row == latched row -> ISSUE (row hit).
  - bank_active[b] and row differs -> SEND_PRE (conflict).
  - otherwise -> SEND_ACT (bank idle).
- SEND_PRE: precharge[b]=1 for exactly this one cycle -> WAIT_PRE.
- WAIT_PRE: wait until bank_blocked[b]=0, then -> CHECK. CHECK then sees the bank inactive and proceeds to SEND_ACT.
- SEND_ACT: activate[b]=1 and row_address=latched row for exactly one cycle -> WAIT_ACT.
- WAIT_ACT: wait until bank_blocked[b]=0 and bank_ready[b]=1, then -> ISSUE.
- ISSUE: cmd_valid=1 with stable cmd_* fields; hold until cmd_ready. On the handshake -> IDLE.
- Because the tracker registers the pulse, blocked is already 1 on the first WAIT cycle; the WAIT states must not sample before that cycle.
- Latency from request acceptance:
  - Hit: cmd_valid asserts 2 cycles after the acceptance edge.
  - Idle bank: 3 cycles plus the tracker's blocked duration.
  - Conflict: adds SEND_PRE, the precharge blocked duration and one CHECK cycle on top of the idle-bank path.
- Back-to-back: after the cmd handshake, req_ready is high in the next cycle, giving a minimum of 3 cycles per request.
- Never asserts precharge and activate in the same cycle; never pulses any bank other than b.
- Reset mid-operation: the latched request is discarded and no pulse is emitted after reset asserts.
- cmd_ready held low indefinitely: the block stalls in ISSUE with all fields stable.

Optional Feature:
- Macro: SDRAM_ISSUER_STATS_EN.
- When defined, adds three output ports stat_hits, stat_misses and stat_conflicts, each 16 bits.
  - A counter increments on the first CHECK evaluation of a request that is not blocked.
  - Counters saturate at 16'hFFFF and reset to 0.
- When undefined, these ports and the counter logic do not exist.

Decomposition:
- Package sdram_pkg holds:
  - issuer_state_t enum
  - mem_req_t struct (write, bank, row, col)
  - bank_row_t typedef
  - the shared ROW_WIDTH/COL_WIDTH defaults
- Sub-module sdram_issuer_stats holds the saturating counters and is instantiated only under SDRAM_ISSUER_STATS_EN.

Test Plan:
- Idle bank 2, read row 0x55, cmd_ready=1, tracker with ACTIVATION_LATENCY=8 -> one activate[2] pulse with row_address=0x55, no precharge, then cmd_valid with bank=2 and the correct col once blocked clears.
- Second read to bank 2 row 0x55 -> no pulses; cmd_valid 2 cycles after acceptance.
- Bank 2 open on 0x55, write row 0x77 -> precharge[2] pulse, wait, then activate[2] with row 0x77, then cmd_valid with cmd_write=1.
- cmd_ready held low for 10 cycles in ISSUE -> cmd_* stable and req_ready=0 throughout; IDLE the cycle after cmd_ready.
- rst asserted during WAIT_ACT -> outputs immediately at reset values; a new request afterwards behaves as from power-up.
- With SDRAM_ISSUER_STATS_EN defined: 1 miss, 2 hits, 1 conflict -> stat_misses=1, stat_hits=2, stat_conflicts=1; forced 70000 hits -> stat_hits=16'hFFFF.
